reaction_stimulus: RTL

Front-end stage directly upstream of the reaction timer. It runs one reaction round per start request:
- waits a pseudo-random delay, then lights the LED (`led_on`)
- debounces the player's button
- on a valid press, drops `led_on` and issues a one-cycle clean press pulse, so the downstream timer freezes its count and captures it
- flags false starts and timeouts, then enforces a cooldown before the next round.

---
 rtl/reaction_stimulus.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/reaction_stimulus.sv
// Reaction-round front end: random pre-LED delay, debounced button, press/false-start/timeout pulses, cooldown.
// Optional: define REACTION_FALSE_START_EN to let a press during WAIT abort the round.
module reaction_stimulus #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MIN_WAIT_CYCLES = 32,
  parameter int unsigned TIMEOUT_CYCLES  = 200,
  parameter int unsigned COOLDOWN_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic button_raw,
  output logic led_on,
  output logic press_pulse,
  output logic false_start,
  output logic timeout,
  output logic busy
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned WAIT_W = 16;
  localparam int unsigned LIT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned COOL_W = $clog2(COOLDOWN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LIT,
    S_HOLD,
    S_COOL
  } state_e;

  logic              sync1_q, sync2_q;
  logic              deb_q, deb_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic              press_evt_q;
  logic [7:0]        lfsr_q;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [LIT_W-1:0]  lit_cnt_q, lit_cnt_d;
  logic [COOL_W-1:0] cool_cnt_q, cool_cnt_d;
  logic              led_q, led_d;
  logic              pulse_q, pulse_d;
  logic              fs_q, fs_d;
  logic              to_q, to_d;
  logic              busy_q, busy_d;

  // Debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = ~deb_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      deb_q       <= 1'b0;
      deb_cnt_q   <= '0;
      press_evt_q <= 1'b0;
      lfsr_q      <= 8'hA5;
    end else begin
      sync1_q     <= button_raw;
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      deb_cnt_q   <= deb_cnt_d;
      press_evt_q <= deb_d & ~deb_q;
      lfsr_q      <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  // Round sequencing: next state and registered output values.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    lit_cnt_d  = lit_cnt_q;
    cool_cnt_d = cool_cnt_q;
    led_d      = 1'b0;
    pulse_d    = 1'b0;
    fs_d       = 1'b0;
    to_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_WAIT;
          wait_cnt_d = WAIT_W'(MIN_WAIT_CYCLES) + WAIT_W'(lfsr_q);
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_W'(1)) begin
          state_d   = S_LIT;
          led_d     = 1'b1;
          lit_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
`ifdef REACTION_FALSE_START_EN
        if (press_evt_q) begin
          state_d    = S_COOL;
          led_d      = 1'b0;
          fs_d       = 1'b1;
          cool_cnt_d = '0;
        end
`endif
      end
      S_LIT: begin
        led_d = 1'b1;
        if (press_evt_q) begin
          state_d = S_HOLD;
          led_d   = 1'b0;
          pulse_d = 1'b1;
        end else if (lit_cnt_q == LIT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d    = S_COOL;
          led_d      = 1'b0;
          to_d       = 1'b1;
          cool_cnt_d = '0;
        end else begin
          lit_cnt_d = lit_cnt_q + LIT_W'(1);
        end
      end
      // LED already low while the pulse is high, so the timer sees the press against a dark LED.
      S_HOLD: begin
        state_d    = S_COOL;
        cool_cnt_d = '0;
      end
      S_COOL: begin
        if (cool_cnt_q == COOL_W'(COOLDOWN_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          cool_cnt_d = cool_cnt_q + COOL_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      lit_cnt_q  <= '0;
      cool_cnt_q <= '0;
      led_q      <= 1'b0;
      pulse_q    <= 1'b0;
      fs_q       <= 1'b0;
      to_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      lit_cnt_q  <= lit_cnt_d;
      cool_cnt_q <= cool_cnt_d;
      led_q      <= led_d;
      pulse_q    <= pulse_d;
      fs_q       <= fs_d;
      to_q       <= to_d;
      busy_q     <= busy_d;
    end
  end

  assign led_on      = led_q;
  assign press_pulse = pulse_q;
  assign false_start = fs_q;
  assign timeout     = to_q;
  assign busy        = busy_q;

endmodule
